// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit beside ID: per-register countdowns for
// long-latency writers, multi-cycle unit occupancy and flush undo.
module hazard_scoreboard #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned CNT_W    = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MC_LAT   = 4,
    parameter int unsigned STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mc_op,
    input  logic              ex_flush,
    output logic              stall,
    output logic [1:0]        stall_cause,
    output logic [STAT_W-1:0] stall_count
);

    localparam int unsigned NREG = 1 << REG_AW;
    localparam logic [CNT_W-1:0] LD_L = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] MC_L = CNT_W'(MC_LAT);

    logic [CNT_W-1:0]  pend_q [NREG];
    logic [CNT_W-1:0]  pend_d [NREG];
    logic [CNT_W-1:0]  base   [NREG];
    logic [CNT_W-1:0]  mc_busy_q, mc_busy_d, mc_base;
    logic              last_valid_q, last_valid_d;
    logic [REG_AW-1:0] last_rd_q, last_rd_d;
    logic              last_mc_q, last_mc_d;
    logic [CNT_W-1:0]  last_prev_q, last_prev_d;
    logic [CNT_W-1:0]  last_mc_prev_q, last_mc_prev_d;
    logic [STAT_W-1:0] stall_count_q, stall_count_d;

    logic              raw, strct, issue, flush_hit, rec;
    logic [CNT_W-1:0]  lat, rd_dec;

    function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] x);
        return (x == '0) ? x : x - 1'b1;
    endfunction

    always_comb begin
        raw = id_valid &&
              ((id_rs1_used && id_rs1 != '0 && pend_q[id_rs1] != '0) ||
               (id_rs2_used && id_rs2 != '0 && pend_q[id_rs2] != '0));
        strct = id_valid && id_mc_op && mc_busy_q != '0;
        stall = raw | strct;
        stall_cause = {strct, raw};
        issue = id_valid && !stall;
    end

    // Flush restores the squashed writer's entries; issue then lands on top.
    always_comb begin
        flush_hit = ex_flush && last_valid_q;
        for (int r = 0; r < NREG; r++) begin
            base[r] = (flush_hit && last_rd_q == REG_AW'(r)) ? last_prev_q : pend_q[r];
            pend_d[r] = dec(base[r]);
        end
        mc_base = (flush_hit && last_mc_q) ? last_mc_prev_q : mc_busy_q;
        mc_busy_d = dec(mc_base);

        lat = id_mc_op ? MC_L : (id_mem_read ? LD_L : '0);
        rec = issue && id_reg_write && id_rd != '0 && lat != '0;
        rd_dec = dec(base[id_rd]);
        if (rec)
            pend_d[id_rd] = (rd_dec > lat) ? rd_dec : lat;
        if (issue && id_mc_op)
            mc_busy_d = MC_L;

        last_valid_d   = issue && !ex_flush;
        last_rd_d      = id_rd;
        last_mc_d      = id_mc_op;
        last_prev_d    = rd_dec;
        last_mc_prev_d = dec(mc_base);

        stall_count_d = stall_count_q;
        if (stall && !(&stall_count_q))
            stall_count_d = stall_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++)
                pend_q[r] <= '0;
            mc_busy_q      <= '0;
            last_valid_q   <= 1'b0;
            last_rd_q      <= '0;
            last_mc_q      <= 1'b0;
            last_prev_q    <= '0;
            last_mc_prev_q <= '0;
            stall_count_q  <= '0;
        end else begin
            for (int r = 0; r < NREG; r++)
                pend_q[r] <= pend_d[r];
            mc_busy_q      <= mc_busy_d;
            last_valid_q   <= last_valid_d;
            last_rd_q      <= last_rd_d;
            last_mc_q      <= last_mc_d;
            last_prev_q    <= last_prev_d;
            last_mc_prev_q <= last_mc_prev_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed checks of hazard_scoreboard against a
// ready-cycle reference model.
module tb_hazard_scoreboard;

    localparam int LOAD_LAT = 1;
    localparam int MC_LAT   = 4;

    logic        clk, rst;
    logic        id_valid, id_rs1_used, id_rs2_used;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_reg_write, id_mem_read, id_mc_op, ex_flush;
    logic        stall;
    logic [1:0]  stall_cause;
    logic [31:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scoreboard #(
        .REG_AW(5), .CNT_W(3), .LOAD_LAT(LOAD_LAT),
        .MC_LAT(MC_LAT), .STAT_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mc_op(id_mc_op),
        .ex_flush(ex_flush),
        .stall(stall), .stall_cause(stall_cause),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: absolute cycle at which each register / the mc unit is free.
    int now;
    int ready [32];
    int mc_free;
    int m_last_valid, m_last_rd, m_last_mc;
    int m_saved_ready, m_saved_mc;
    int exp_cnt;
    logic e_raw, e_str, e_stall;

    task automatic model_reset();
        for (int r = 0; r < 32; r++) ready[r] = 0;
        mc_free = 0;
        m_last_valid = 0;
        m_last_rd = 0;
        m_last_mc = 0;
        m_saved_ready = 0;
        m_saved_mc = 0;
        exp_cnt = 0;
    endtask

    task automatic model_eval();
        e_raw = id_valid &&
                ((id_rs1_used && id_rs1 != 0 && ready[id_rs1] > now) ||
                 (id_rs2_used && id_rs2 != 0 && ready[id_rs2] > now));
        e_str = id_valid && id_mc_op && mc_free > now;
        e_stall = e_raw || e_str;
    endtask

    task automatic model_clock();
        int lat;
        bit iss;
        if (ex_flush && m_last_valid != 0) begin
            ready[m_last_rd] = m_saved_ready;
            if (m_last_mc != 0) mc_free = m_saved_mc;
        end
        iss = id_valid && !e_stall;
        lat = id_mc_op ? MC_LAT : (id_mem_read ? LOAD_LAT : 0);
        m_saved_ready = ready[id_rd];
        m_saved_mc = mc_free;
        if (iss && id_reg_write && id_rd != 0 && lat != 0)
            if (now + 1 + lat > ready[id_rd]) ready[id_rd] = now + 1 + lat;
        if (iss && id_mc_op) mc_free = now + 1 + MC_LAT;
        m_last_valid = (iss && !ex_flush) ? 1 : 0;
        m_last_rd = id_rd;
        m_last_mc = id_mc_op;
        if (e_stall) exp_cnt++;
        now++;
    endtask

    task automatic tick();
        model_eval();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input int rs1, input logic u1,
                          input int rs2, input logic u2, input int rd,
                          input logic wr, input logic mr, input logic mc,
                          input logic fl);
        id_valid = v;
        id_rs1 = 5'(rs1);
        id_rs1_used = u1;
        id_rs2 = 5'(rs2);
        id_rs2_used = u2;
        id_rd = 5'(rd);
        id_reg_write = wr;
        id_mem_read = mr;
        id_mc_op = mc;
        ex_flush = fl;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_id(1, 3, 1, 3, 1, 4, 1, 0, 1, 0);
        #1 rst = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b want 0", stall);
        end
        n_tests++;
        if (stall_cause !== 2'b00) begin
            n_fail++; $display("FAIL reset_cause: got %b want 00", stall_cause);
        end
        n_tests++;
        if (stall_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", stall_count);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        now = 0;
    endtask

    task automatic test_load_use();
        set_id(1, 1, 1, 2, 1, 5, 1, 1, 0, 0);
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL lu_load: stall got %b want 0", stall);
        end
        tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b1 || stall_cause !== 2'b01) begin
            n_fail++;
            $display("FAIL lu_stall: stall/cause got %b/%b want 1/01", stall, stall_cause);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL lu_issue: stall got %b want 0", stall);
        end
        tick();
        idle(1);
        n_tests++;
        if (stall_count !== 32'd1) begin
            n_fail++; $display("FAIL lu_count: got %0d want 1", stall_count);
        end
        idle(5);
    endtask

    task automatic test_imm_form();
        set_id(1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
        tick();
        set_id(1, 2, 1, 5, 0, 8, 1, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL imm_nostall: stall got %b want 0", stall);
        end
        tick();
        idle(6);
    endtask

    task automatic test_mc();
        logic want;
        set_id(1, 1, 1, 2, 1, 7, 1, 0, 1, 0);
        tick();
        set_id(1, 7, 1, 0, 0, 12, 1, 0, 1, 0);
        for (int c = 1; c <= 5; c++) begin
            want = (c <= 4);
            @(negedge clk);
            n_tests++;
            if (stall !== want || (want && stall_cause !== 2'b11)) begin
                n_fail++;
                $display("FAIL mc_c%0d: stall/cause got %b/%b want %b/%s",
                         c, stall, stall_cause, want, want ? "11" : "xx");
            end
            tick();
        end
        idle(6);
    endtask

    task automatic test_waw_flush();
        logic want;
        set_id(1, 0, 0, 0, 0, 9, 1, 0, 1, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
        tick();
        for (int c = 2; c <= 5; c++) begin
            set_id(1, 9, 1, 0, 0, 14, 1, 0, 0, c == 2);
            want = (c <= 4);
            @(negedge clk);
            n_tests++;
            if (stall !== want) begin
                n_fail++; $display("FAIL waw_c%0d: stall got %b want %b", c, stall, want);
            end
            tick();
        end
        idle(6);
    endtask

    task automatic test_flush_restore();
        set_id(1, 0, 0, 0, 0, 13, 1, 1, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 13, 1, 0, 1, 0);
        tick();
        set_id(1, 13, 1, 0, 0, 15, 1, 0, 1, 1);
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b1 || stall_cause !== 2'b11) begin
            n_fail++;
            $display("FAIL fr_pre: stall/cause got %b/%b want 1/11", stall, stall_cause);
        end
        tick();
        ex_flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL fr_restored: stall got %b want 0", stall);
        end
        tick();
        idle(6);
    endtask

    task automatic test_x0();
        set_id(1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
        tick();
        set_id(1, 0, 1, 0, 1, 6, 1, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL x0_nostall: stall got %b want 0", stall);
        end
        tick();
        idle(2);
    endtask

    task automatic test_flush_idle();
        logic want;
        set_id(1, 0, 0, 0, 0, 7, 1, 0, 1, 0);
        tick();
        for (int c = 1; c <= 5; c++) begin
            set_id(1, 7, 1, 0, 0, 16, 1, 0, 0, c == 2);
            want = (c <= 4);
            @(negedge clk);
            n_tests++;
            if (stall !== want) begin
                n_fail++; $display("FAIL fi_c%0d: stall got %b want %b", c, stall, want);
            end
            tick();
        end
        idle(6);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            set_id($urandom_range(0, 9) < 8,
                   $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 4) == 0);
            @(negedge clk);
            model_eval();
            n_tests++;
            if (stall !== e_stall) begin
                n_fail++; $display("FAIL rnd_stall@%0d: got %b want %b", i, stall, e_stall);
            end
            n_tests++;
            if (stall_cause !== {e_str, e_raw}) begin
                n_fail++;
                $display("FAIL rnd_cause@%0d: got %b want %b", i, stall_cause, {e_str, e_raw});
            end
            n_tests++;
            if (stall_count !== 32'(exp_cnt)) begin
                n_fail++;
                $display("FAIL rnd_count@%0d: got %0d want %0d", i, stall_count, exp_cnt);
            end
            tick();
        end
        idle(6);
    endtask

    task automatic test_reset_mid();
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 1, 0);
        tick();
        idle(1);
        set_id(1, 3, 1, 3, 1, 4, 1, 0, 1, 0);
        rst = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (stall !== 1'b0 || stall_cause !== 2'b00 || stall_count !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: stall/cause/count got %b/%b/%0d want 0/00/0",
                     stall, stall_cause, stall_count);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL mid_after: stall got %b want 0", stall);
        end
        tick();
    endtask

    initial begin
        now = 0;
        model_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_imm_form();
        test_mc();
        test_waw_flush();
        test_flush_restore();
        test_x0();
        test_flush_idle();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
